// File: rtl/noc_alloc_pkg.sv
// Shared types and width helpers for the NoC output allocator.
//   alloc_state_e : allocator FSM states
//   credit_width  : width needed to hold a credit count of 0..depth
//   index_width   : width needed to index n requesters (at least 1 bit)
package noc_alloc_pkg;

    typedef enum logic [0:0] {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_output_allocator_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr, scanning upward with wrap-around.
//   req   : request vector
//   ptr   : starting index (expected to be < N)
//   grant : one-hot winner, zero when no request
//   idx   : index of the winner
//   any   : at least one request asserted
module noc_rr_pick #(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Unrolled scan; the extra sum bit keeps ptr+k from overflowing before wrap.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            j = sum[IDX_W-1:0];
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output switch allocator: round-robin arbitration among inputs whose head
// flit targets this output, wormhole locking until the tail passes, and
// downstream credit tracking.
// Optional feature macro: NOC_ALLOC_TURN_MASK_EN adds turn_mask, which removes
// masked requesters from arbitration (an existing lock is never broken).
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-input head flit routed here
//   is_tail     : per-input tail qualifier for the presented flit
//   credit_in   : downstream freed one slot (one-cycle pulse)
//   turn_mask   : (macro only) per-input arbitration disable
//   grant, send : combinational dequeue select / flit transfer
//   locked      : output held by a packet in progress
//   owner       : current or last packet owner
//   credits     : registered credit count
//   credit_err  : sticky credit overflow flag
module noc_output_allocator
    import noc_alloc_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS        = 5,
    parameter  int unsigned FLIT_BUFFER_DEPTH = 4,
    parameter  int unsigned CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH),
    localparam int unsigned IDX_W             = index_width(NUM_INPUTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   is_tail,
    input  logic                    credit_in,
`ifdef NOC_ALLOC_TURN_MASK_EN
    input  logic [NUM_INPUTS-1:0]   turn_mask,
`endif
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send,
    output logic                    locked,
    output logic [IDX_W-1:0]        owner,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    credit_err
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(NUM_INPUTS - 1);

    alloc_state_e          state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  send_tail;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Masking applies to new arbitration only; the owner bypasses it.
`ifdef NOC_ALLOC_TURN_MASK_EN
    assign eligible = req & ~turn_mask;
`else
    assign eligible = req;
`endif

    noc_rr_pick #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign locked = (state == ALLOC_LOCKED);

    // Same-cycle grant from registered credits; held at zero during reset.
    always_comb begin
        send      = 1'b0;
        grant     = '0;
        send_tail = 1'b0;
        if (rst_n && (credits != '0)) begin
            if (state == ALLOC_LOCKED) begin
                if (req[owner]) begin
                    send         = 1'b1;
                    grant[owner] = 1'b1;
                    send_tail    = is_tail[owner];
                end
            end else if (pick_any) begin
                send      = 1'b1;
                grant     = pick_grant;
                send_tail = is_tail[pick_idx];
            end
        end
    end

    // FSM, round-robin pointer, owner and credit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALLOC_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            credits    <= CREDIT_FULL;
            credit_err <= 1'b0;
        end else begin
            unique case ({send, credit_in})
                2'b10: credits <= credits - CREDIT_WIDTH'(1);
                2'b01: begin
                    if (credits == CREDIT_FULL) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CREDIT_WIDTH'(1);
                    end
                end
                default: ;
            endcase

            if (send) begin
                unique case (state)
                    ALLOC_IDLE: begin
                        if (send_tail) begin
                            rr_ptr <= idx_inc(pick_idx);
                        end else begin
                            state <= ALLOC_LOCKED;
                            owner <= pick_idx;
                        end
                    end
                    ALLOC_LOCKED: begin
                        if (send_tail) begin
                            state  <= ALLOC_IDLE;
                            rr_ptr <= idx_inc(owner);
                        end
                    end
                    default: state <= ALLOC_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_output_allocator.sv
// Scoreboard bench for noc_output_allocator: the driver computes expected
// outputs from a behavioural model and queues them; a monitor compares.
module tb_noc_output_allocator;

    localparam int N = 5;
    localparam int D = 4;

`ifdef NOC_ALLOC_TURN_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] is_tail;
    logic         credit_in;
    logic [N-1:0] turn_mask;
    logic [N-1:0] grant;
    logic         send;
    logic         locked;
    logic [2:0]   owner;
    logic [2:0]   credits;
    logic         credit_err;

    always #5 clk = ~clk;

    noc_output_allocator #(
        .NUM_INPUTS        (N),
        .FLIT_BUFFER_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .is_tail    (is_tail),
        .credit_in  (credit_in),
`ifdef NOC_ALLOC_TURN_MASK_EN
        .turn_mask  (turn_mask),
`endif
        .grant      (grant),
        .send       (send),
        .locked     (locked),
        .owner      (owner),
        .credits    (credits),
        .credit_err (credit_err)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic         send;
        logic [2:0]   credits;
        logic         locked;
        logic [2:0]   owner;
        logic         cerr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: packet in flight, owner, pointer, credits.
    bit m_busy;
    int m_own;
    int m_rr;
    int m_cred;
    bit m_cerr;
    int rem[N];

    function automatic int model_win(input logic [N-1:0] r, input logic [N-1:0] mask);
        if (m_cred == 0) return -1;
        if (m_busy) return r[m_own] ? m_own : -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (r[j] && !mask[j]) return j;
        end
        return -1;
    endfunction

    task automatic step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] t,
                        input bit cin, input logic [N-1:0] mask);
        exp_t e;
        int   w;
        @(negedge clk);
        rst_n     = rst;
        req       = r;
        is_tail   = t;
        credit_in = cin;
        turn_mask = mask;
        if (!rst) begin
            m_busy = 1'b0; m_own = 0; m_rr = 0; m_cred = D; m_cerr = 1'b0;
            for (int i = 0; i < N; i++) rem[i] = 0;
            w = -1;
        end else begin
            w = model_win(r, mask);
        end
        e.grant = '0;
        if (w >= 0) e.grant[w] = 1'b1;
        e.send    = (w >= 0);
        e.credits = 3'(m_cred);
        e.locked  = m_busy;
        e.owner   = 3'(m_own);
        e.cerr    = m_cerr;
        sb.push_back(e);
        if (rst) begin
            if (w >= 0) begin
                if (t[w]) begin
                    m_busy = 1'b0;
                    m_rr   = (w + 1) % N;
                end else if (!m_busy) begin
                    m_busy = 1'b1;
                    m_own  = w;
                end
            end
            if (w >= 0 && !cin) m_cred--;
            else if (w < 0 && cin) begin
                if (m_cred == D) m_cerr = 1'b1;
                else m_cred++;
            end
        end
    endtask

    // cmode: 0 no credits, 1 random credits with request stalls, 2 credit on every send/deficit.
    task automatic run(input int cycles, input int cmode, input int start_pct, input logic [N-1:0] mask);
        for (int c = 0; c < cycles; c++) begin
            logic [N-1:0] r;
            logic [N-1:0] t;
            bit cin;
            int w;
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 99) < start_pct) rem[i] = $urandom_range(1, 4);
                r[i] = (rem[i] > 0) && (cmode != 1 || $urandom_range(0, 9) != 0);
                t[i] = (rem[i] == 1);
            end
            w = model_win(r, mask);
            case (cmode)
                0:       cin = 1'b0;
                1:       cin = (m_cred < D) && ($urandom_range(0, 1) == 1);
                default: cin = (m_cred < D) || (w >= 0);
            endcase
            step(1'b1, r, t, cin, mask);
            if (w >= 0) rem[w]--;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant",      32'(grant),      32'(e.grant));
                chk("send",       32'(send),       32'(e.send));
                chk("credits",    32'(credits),    32'(e.credits));
                chk("locked",     32'(locked),     32'(e.locked));
                chk("owner",      32'(owner),      32'(e.owner));
                chk("credit_err", 32'(credit_err), 32'(e.cerr));
            end
        end
    end

    initial begin
        logic [N-1:0] mask;
        rst_n = 1'b0; req = '0; is_tail = '0; credit_in = 1'b0; turn_mask = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset, idle, single-flit packet, then pointer resumes after input 2.
        step(1'b0, '0, '0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0);
        step(1'b1, '0, '0, 1'b0, '0);
        step(1'b1, 5'b00100, 5'b00100, 1'b0, '0);
        step(1'b1, 5'b11111, 5'b11111, 1'b1, '0);
        step(1'b1, '0, '0, 1'b1, '0);

        // Contention: three 3-flit packets back to back.
        step(1'b0, '0, '0, 1'b0, '0);
        rem[0] = 3; rem[1] = 3; rem[4] = 3;
        run(12, 2, 0, '0);

        // Credit exhaustion, then a single returned credit.
        rem[2] = 6;
        run(6, 0, 0, '0);
        step(1'b1, 5'b00100, 5'b00000, 1'b1, '0);
        run(1, 0, 0, '0);
        run(2, 0, 0, '0);
        run(10, 2, 0, '0);

        // Simultaneous send and credit at credits=2, then overflow.
        rem[1] = 4;
        run(2, 0, 0, '0);
        run(1, 2, 0, '0);
        run(8, 2, 0, '0);
        step(1'b1, '0, '0, 1'b1, '0);
        step(1'b1, '0, '0, 1'b0, '0);
        step(1'b1, '0, '0, 1'b1, '0);

        // Reset mid-packet; new head afterwards.
        rem[3] = 4;
        run(2, 2, 0, '0);
        step(1'b0, 5'b01000, 5'b00000, 1'b0, '0);
        step(1'b1, 5'b01000, 5'b00000, 1'b0, '0);
        rem[3] = 3;
        run(6, 2, 0, '0);

        if (MASK_EN) begin
            step(1'b1, 5'b00001, 5'b00001, 1'b0, 5'b00001);
            rem[1] = 4;
            run(2, 2, 0, '0);
            run(40, 2, 30, 5'b00010);
        end

        // Randomised traffic.
        for (int b = 0; b < 20; b++) begin
            mask = MASK_EN ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            run(100, 1, 30, mask);
            if ($urandom_range(0, 3) == 0) step(1'b0, '0, '0, 1'b0, '0);
        end
        run(30, 2, 0, '0);

        repeat (3) @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
